alu_packet_parser: RTL and testbench

Upstream stage of alu32. Consumes the UART receiver's byte stream (valid/ready), frames each 9-byte command packet and presents one ALU command (opcode, operand A, operand B) on a valid/ready interface that feeds alu32 directly. It resynchronises on malformed or stalled packets so that a lost UART byte cannot permanently misalign framing.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/uart_byte_timer.sv | 34 +++
 rtl/alu_packet_parser.sv | 163 ++++++++++++++++
 tb/tb_alu_packet_parser.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: command opcodes and packet framing constants.
package alu_pkg;

    typedef enum logic [1:0] {
        Nop = 2'd0,
        Add = 2'd1,
        Mul = 2'd2,
        Div = 2'd3
    } opcode_e;

    localparam int unsigned PacketBytes   = 9;
    localparam int unsigned OperandBytes  = 4;
    localparam logic [7:0]  HeaderPadMask = 8'hFC;

    // A header byte is legal only when every pad bit above the opcode is zero.
    function automatic logic header_is_valid(input logic [7:0] hdr);
        return (hdr & HeaderPadMask) == 8'h00;
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// flags the final cycle of the allowed window. Cycles == 0 disables it.
module uart_byte_timer #(
    parameter int unsigned Cycles = 100000
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CntW = ($clog2(Cycles + 1) > 0) ? $clog2(Cycles + 1) : 1;

    logic [CntW-1:0] count;

    // Counter holds at zero while disabled so it restarts cleanly on re-entry.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count <= '0;
        end else if (clear_i || !enable_i) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    if (Cycles == 0) begin : g_disabled
        assign expire_o = 1'b0;
    end else begin : g_enabled
        assign expire_o = enable_i && (count == CntW'(Cycles - 1));
    end

endmodule

// File: rtl/alu_packet_parser.sv
// Frames 9-byte command packets from the UART RX byte stream and presents
// one ALU command on a valid/ready interface. Resynchronises on a bad
// header or on an inter-byte stall inside a packet.
module alu_packet_parser
    import alu_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 100000
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        valid_o,
    output logic [1:0]  opcode_o,
    output logic [31:0] operand_a_o,
    output logic [31:0] operand_b_o,
    input  logic        ready_i,
    output logic        bad_opcode_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        StOpcode   = 2'd0,
        StOperandA = 2'd1,
        StOperandB = 2'd2,
        StSend     = 2'd3
    } state_e;

    localparam logic [1:0] LastByte = 2'(OperandBytes - 1);

    state_e      state;
    state_e      state_next;
    opcode_e     opcode_q;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [1:0]  byte_cnt;
    logic        accept;
    logic        in_operand;
    logic        expire;
    logic        timeout_fire;
    logic        bad_header;

    assign rx_ready_o  = (state != StSend);
    assign valid_o     = (state == StSend);
    assign accept      = rx_valid_i && rx_ready_o;
    assign in_operand  = (state == StOperandA) || (state == StOperandB);
    assign opcode_o    = opcode_q;
    assign operand_a_o = operand_a;
    assign operand_b_o = operand_b;

    // Idle window restarts on every accepted byte; frozen outside operand states.
    uart_byte_timer #(
        .Cycles(TimeoutCycles)
    ) u_timer (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .clear_i (accept),
        .enable_i(in_operand),
        .expire_o(expire)
    );

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= StOpcode;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an accepted byte always beats a simultaneous expiry.
    always_comb begin
        state_next   = state;
        timeout_fire = 1'b0;
        bad_header   = 1'b0;
        case (state)
            StOpcode: begin
                if (accept) begin
                    if (header_is_valid(rx_data_i)) begin
                        state_next = StOperandA;
                    end else begin
                        bad_header = 1'b1;
                    end
                end
            end
            StOperandA: begin
                if (accept) begin
                    if (byte_cnt == LastByte) begin
                        state_next = StOperandB;
                    end
                end else if (expire) begin
                    state_next   = StOpcode;
                    timeout_fire = 1'b1;
                end
            end
            StOperandB: begin
                if (accept) begin
                    if (byte_cnt == LastByte) begin
                        state_next = StSend;
                    end
                end else if (expire) begin
                    state_next   = StOpcode;
                    timeout_fire = 1'b1;
                end
            end
            StSend: begin
                if (ready_i) begin
                    state_next = StOpcode;
                end
            end
            default: state_next = StOpcode;
        endcase
    end

    // Command registers and byte counter; operands only change while framing.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            opcode_q  <= Nop;
            operand_a <= '0;
            operand_b <= '0;
            byte_cnt  <= '0;
        end else begin
            case (state)
                StOpcode: begin
                    if (accept && header_is_valid(rx_data_i)) begin
                        opcode_q <= opcode_e'(rx_data_i[1:0]);
                        byte_cnt <= '0;
                    end
                end
                StOperandA: begin
                    if (accept) begin
                        operand_a[8*byte_cnt +: 8] <= rx_data_i;
                        byte_cnt                   <= byte_cnt + 1'b1;
                    end else if (timeout_fire) begin
                        byte_cnt <= '0;
                    end
                end
                StOperandB: begin
                    if (accept) begin
                        operand_b[8*byte_cnt +: 8] <= rx_data_i;
                        byte_cnt                   <= byte_cnt + 1'b1;
                    end else if (timeout_fire) begin
                        byte_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // One-cycle status pulses, registered so they appear the cycle after the event.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            bad_opcode_o <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            bad_opcode_o <= bad_header;
            timeout_o    <= timeout_fire;
        end
    end

endmodule

// File: tb/tb_alu_packet_parser.sv
// Scoreboard bench for alu_packet_parser with a short idle timeout.
module tb_alu_packet_parser;

    localparam int unsigned TimeoutCycles = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        valid;
    logic [1:0]  opcode;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        ready;
    logic        bad_opcode;
    logic        timeout;

    int checks   = 0;
    int failures = 0;
    int n_cmds   = 0;
    int n_bad    = 0;
    int n_tmo    = 0;
    int n_pushed = 0;

    logic [65:0] exp_q[$];

    alu_packet_parser #(
        .TimeoutCycles(TimeoutCycles)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (rst_n),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .rx_ready_o  (rx_ready),
        .valid_o     (valid),
        .opcode_o    (opcode),
        .operand_a_o (operand_a),
        .operand_b_o (operand_b),
        .ready_i     (ready),
        .bad_opcode_o(bad_opcode),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every command handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bad_opcode) n_bad++;
            if (timeout) n_tmo++;
            if (valid && ready) begin
                n_cmds++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_cmd", 96'd1, 96'd0);
                end else begin
                    logic [65:0] e;
                    e = exp_q.pop_front();
                    check_eq("cmd_opcode", 96'(opcode), 96'(e[65:64]));
                    check_eq("cmd_operand_a", 96'(operand_a), 96'(e[63:32]));
                    check_eq("cmd_operand_b", 96'(operand_b), 96'(e[31:0]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done     = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 100 && !done; i++) begin
            if (rx_ready) done = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        if (!done) check_eq("send_byte_stuck", 96'd0, 96'd1);
    endtask

    task automatic send_packet(input logic [7:0] hdr, input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back({hdr[1:0], a, b});
        n_pushed++;
        send_byte(hdr);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check_eq("drain", 96'(exp_q.size()), 96'd0);
    endtask

    initial begin
        int bad0;
        int tmo0;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        ready    = 1'b1;
        repeat (3) tick();
        check_eq("rst_valid", 96'(valid), 96'd0);
        check_eq("rst_rx_ready", 96'(rx_ready), 96'd1);
        check_eq("rst_pulses", 96'({bad_opcode, timeout}), 96'd0);
        check_eq("rst_operands", 96'({opcode, operand_a, operand_b}), 96'd0);
        rst_n = 1'b1;
        tick();

        // Basic Add packet, valid_o one cycle after the final byte.
        send_packet(8'h01, 32'h12345678, 32'h00000001);
        check_eq("latency_valid", 96'(valid), 96'd1);
        wait_drain();

        // Backpressure: everything held, no timeout while stalled.
        ready = 1'b0;
        tmo0  = n_tmo;
        send_packet(8'h02, 32'hDEADBEEF, 32'hCAFEF00D);
        for (int i = 0; i < 20; i++) begin
            check_eq("stall_hold", {valid, rx_ready, opcode, operand_a, operand_b},
                     {1'b1, 1'b0, 2'd2, 32'hDEADBEEF, 32'hCAFEF00D});
            tick();
        end
        check_eq("stall_no_timeout", 96'(n_tmo - tmo0), 96'd0);
        ready = 1'b1;
        tick();
        check_eq("post_handshake", 96'({valid, rx_ready}), 96'b01);
        wait_drain();

        // Bad header discarded, following packet framed correctly.
        bad0 = n_bad;
        send_byte(8'h41);
        tick();
        check_eq("bad_pulse_count", 96'(n_bad - bad0), 96'd1);
        check_eq("bad_stays_idle", 96'({valid, rx_ready}), 96'b01);
        send_packet(8'h01, 32'h00000010, 32'hFFFFFFFF);
        wait_drain();

        // Stall after three bytes: discarded after eight idle cycles.
        tmo0 = n_tmo;
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (7) tick();
        check_eq("tmo_not_early", 96'(timeout), 96'd0);
        tick();
        check_eq("tmo_pulse", 96'(timeout), 96'd1);
        tick();
        check_eq("tmo_pulse_count", 96'(n_tmo - tmo0), 96'd1);
        check_eq("tmo_idle_valid", 96'(valid), 96'd0);
        send_packet(8'h03, 32'h87654321, 32'h00000007);
        wait_drain();

        // Byte arriving exactly on the expiry cycle is accepted.
        tmo0 = n_tmo;
        exp_q.push_back({2'd1, 32'h44332211, 32'h88776655});
        n_pushed++;
        send_byte(8'h01);
        send_byte(8'h11);
        repeat (7) tick();
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h55 + 8'(i * 17)));
        wait_drain();
        check_eq("expiry_byte_no_tmo", 96'(n_tmo - tmo0), 96'd0);

        // Reset mid-packet drops the partial command silently.
        bad0 = n_bad;
        tmo0 = n_tmo;
        send_byte(8'h02);
        for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("rstmid_state", 96'({valid, rx_ready}), 96'b01);
        repeat (4) tick();
        check_eq("rstmid_no_pulse", 96'({n_bad - bad0, n_tmo - tmo0}), 96'd0);
        send_packet(8'h00, 32'h0BADF00D, 32'h00C0FFEE);
        wait_drain();

        repeat (3) tick();
        check_eq("cmd_count", 96'(n_cmds), 96'(n_pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
